// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned restoring divider with the HI/LO register pair behind it.
// HI receives the remainder and LO the quotient; mfhi/mflo reads stall while a divide is in flight.
module divu_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [1:0]       hilo_sel,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [CNT_W-1:0] count_next;
    logic             last_iter;

    // One restoring step; the extra top bit keeps the shifted-out remainder bit in the compare.
    always_comb begin
        trial      = {rem_reg, quo_reg[WIDTH-1]};
        diff       = trial - {1'b0, dsr_reg};
        trial_ge   = (trial >= {1'b0, dsr_reg});
        rem_next   = trial_ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next   = {quo_reg[WIDTH-2:0], trial_ge};
        count_next = count_reg + CNT_W'(1);
        last_iter  = (count_next == CNT_W'(WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dsr_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (div_start) begin
                        rem_reg   <= '0;
                        quo_reg   <= dividend;
                        dsr_reg   <= divisor;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    rem_reg   <= rem_next;
                    quo_reg   <= quo_next;
                    count_reg <= count_next;
                    if (last_iter) begin
                        hi_reg    <= rem_next;
                        lo_reg    <= quo_next;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // Starts seen here are dropped; only IDLE accepts a new divide.
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    logic rd_hi;
    logic rd_lo;
    assign rd_hi = (hilo_sel == 2'b00);
    assign rd_lo = (hilo_sel == 2'b01);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rd_mux
            assign hilo_rdata[gi] = (rd_hi & hi_reg[gi]) | (rd_lo & lo_reg[gi]);
        end
    endgenerate

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign stall = busy_reg & (rd_hi | rd_lo);

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Scoreboarded bench for divu_hilo_unit: expected HI/LO pushed at start, popped on done.
module tb_divu_hilo_unit;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [1:0]  hilo_sel;
    logic [31:0] hilo_rdata;
    logic        busy;
    logic        done;
    logic        stall;

    divu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .hilo_sel  (hilo_sel),
        .hilo_rdata(hilo_rdata),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one cycle and push the reference result.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input bit push);
        res_t r;
        if (b == 32'd0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = a;
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        if (push) sb.push_back(r);
        div_start = 1'b1;
        dividend  = a;
        divisor   = b;
        step();
        div_start = 1'b0;
        $display("start divu %0d / %0d", a, b);
    endtask

    // Walk cycles after the accepting edge until done, checking busy/stall/rdata each cycle.
    // inj1/inj2 name cycles in which a spurious 9/3 start is driven.
    task automatic wait_done(input int inj1, input int inj2, input logic [1:0] sel);
        bit   seen;
        res_t r;
        seen     = 1'b0;
        hilo_sel = sel;
        #1;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
                check_val("done_cycle", c, 33);
                check_val("busy_done", {31'd0, busy}, 32'd1);
                check_val("stall_done", {31'd0, stall}, {31'd0, ~sel[1]});
                if (sb.size() == 0) begin
                    check_val("sb_empty", 32'd1, 32'd0);
                end else begin
                    r = sb.pop_front();
                    hilo_sel = 2'b00;
                    #1;
                    check_val("hi_result", hilo_rdata, r.hi);
                    hilo_sel = 2'b01;
                    #1;
                    check_val("lo_result", hilo_rdata, r.lo);
                    hilo_sel = sel;
                    prev_hi  = r.hi;
                    prev_lo  = r.lo;
                    $display("done divu: HI=0x%08h LO=0x%08h", r.hi, r.lo);
                end
            end else begin
                check_val("busy_run", {31'd0, busy}, 32'd1);
                check_val("stall_run", {31'd0, stall}, {31'd0, ~sel[1]});
                check_val("rdata_run", hilo_rdata,
                          (sel == 2'b00) ? prev_hi : (sel == 2'b01) ? prev_lo : 32'd0);
            end
            div_start = (c == inj1) || (c == inj2);
            dividend  = 32'd9;
            divisor   = 32'd3;
            step();
        end
        div_start = 1'b0;
        if (!seen) check_val("done_timeout", 32'd0, 32'd1);
        check_val("busy_after", {31'd0, busy}, 32'd0);
        check_val("done_after", {31'd0, done}, 32'd0);
    endtask

    task automatic read_check(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        hilo_sel = sel;
        #1;
        check_val(tag, hilo_rdata, exp);
    endtask

    initial begin
        int done_seen;
        rst       = 1'b1;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        hilo_sel  = 2'b00;
        step();
        step();
        rst = 1'b0;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        read_check("rst_hi", 2'b00, 32'd0);
        read_check("rst_lo", 2'b01, 32'd0);
        hilo_sel = 2'b10;

        // Basic 100/7
        start_div(32'd100, 32'd7, 1'b1);
        wait_done(0, 0, 2'b10);
        read_check("mfhi_100_7", 2'b00, 32'd2);
        read_check("mflo_100_7", 2'b01, 32'd14);

        // Extremes
        start_div(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done(0, 0, 2'b10);
        start_div(32'hFFFF_FFFF, 32'h0001_0000, 1'b1);
        wait_done(0, 0, 2'b10);
        read_check("mfhi_ffff", 2'b00, 32'h0000_FFFF);
        read_check("mflo_ffff", 2'b01, 32'h0000_FFFF);

        // Divide by zero
        start_div(32'd5, 32'd0, 1'b1);
        wait_done(0, 0, 2'b10);

        // Starts during RUN (cycle 5) and DONE (cycle 33) are ignored
        start_div(32'd100, 32'd7, 1'b1);
        wait_done(5, 33, 2'b10);
        step();
        check_val("ignored_start_busy", {31'd0, busy}, 32'd0);
        read_check("ignored_hi", 2'b00, 32'd2);
        read_check("ignored_lo", 2'b01, 32'd14);
        hilo_sel = 2'b10;
        start_div(32'd9, 32'd3, 1'b1);
        wait_done(0, 0, 2'b10);

        // Stall with mfhi held across a divide
        start_div(32'd100, 32'd7, 1'b1);
        wait_done(0, 0, 2'b10);
        start_div(32'd50, 32'd4, 1'b1);
        wait_done(0, 0, 2'b00);
        check_val("stall_after", {31'd0, stall}, 32'd0);
        check_val("mfhi_50_4", hilo_rdata, 32'd2);
        read_check("mflo_50_4", 2'b01, 32'd12);
        read_check("nosel_rdata", 2'b10, 32'd0);
        check_val("nosel_stall", {31'd0, stall}, 32'd0);

        // Reset mid-division aborts with no HI/LO write
        start_div(32'd100, 32'd7, 1'b0);
        for (int c = 1; c < 10; c++) step();
        check_val("busy_pre_abort", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_seen++;
            step();
        end
        check_val("abort_no_done", done_seen, 32'd0);
        read_check("abort_hi", 2'b00, 32'd0);
        read_check("abort_lo", 2'b01, 32'd0);
        prev_hi  = 32'd0;
        prev_lo  = 32'd0;
        hilo_sel = 2'b10;
        start_div(32'd100, 32'd7, 1'b1);
        wait_done(0, 0, 2'b10);

        check_val("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/divu_hilo_unit.md
Name: divu_hilo_unit

Overview:
Multi-cycle unsigned divider and HI/LO register pair. It is the execution-side responder to the divide/HI-LO control issued by ALU control for divu, mfhi and mflo. On a start pulse it runs a 32-iteration restoring division, then writes the remainder to HI and the quotient to LO. It also serves mfhi/mflo reads and raises a stall when a read would see stale data.

Parameters:
WIDTH, 32, operand, quotient, remainder and HI/LO width
CNT_W, 6, iteration counter width; must hold the value WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
div_start  input  1  start request (divu in EX); sampled only in IDLE
dividend  input  WIDTH  rs value, captured on accepted start
divisor  input  WIDTH  rt value, captured on accepted start
hilo_sel  input  2  00 = read HI (mfhi), 01 = read LO (mflo), 10/11 = no read
hilo_rdata  output  WIDTH  selected HI/LO value (combinational)
busy  output  1  division in progress (RUN or DONE)
done  output  1  one-cycle pulse in the cycle after HI/LO are written
stall  output  1  busy & (hilo_sel == 00 or 01)

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; HI=0, LO=0, rem=0, quo=0, dsr=0, count=0.
  - After reset: busy=0, done=0, stall=0, hilo_rdata=0.
  - Reset wins over all other inputs.
  - Reset mid-division aborts the division with no HI/LO write.
- States: IDLE, RUN, DONE.
- IDLE:
  - div_start=1 at edge T → RUN.
  - Load rem=0, quo=dividend, dsr=divisor, count=0.
  - busy=1 from the cycle after edge T.
- RUN, each edge:
  - Form t = {rem, quo[WIDTH-1]} (WIDTH+1 bits). Shift quo left by 1.
  - If t >= {1'b0, dsr}: rem = t - dsr, quo[0] = 1. Else: rem = t[WIDTH-1:0], quo[0] = 0.
  - count = count + 1.
  - On the iteration edge where count reaches WIDTH (edge T+32): HI <= final rem, LO <= final quo, state → DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - The next edge → IDLE, busy=0.
- Latency: busy is high for 33 cycles after the accepting edge, matching the issuer's 33-count window. New HI/LO values are visible on hilo_rdata in the DONE cycle.
- Start in RUN or DONE is ignored. Operands are not re-captured and there is no error flag.
  - A start in the same cycle as DONE is also ignored.
  - A new start is accepted only when state=IDLE.
- Divide by zero: no special case. The algorithm naturally gives LO=all ones and HI=dividend. No trap.
- Reads:
  - hilo_rdata = HI when sel=00, LO when sel=01, 0 otherwise.
  - During busy the registers hold the previous HI/LO, so stall is asserted to freeze the pipeline.
  - In the DONE cycle, stall is still asserted. The read returns new values but is retried the following cycle.
- Arithmetic is unsigned only. No overflow is possible. The comparison uses WIDTH+1 bits so a carry out of the shift is never lost.
- HI/LO are written only at the final RUN edge and by reset. No other path writes them.

Test Plan:
1. Reset, then start with dividend=100, divisor=7 → busy high 33 cycles, done pulses on cycle 33, HI=2, LO=14; mfhi/mflo afterwards read 2 and 14.
2. dividend=0xFFFFFFFF, divisor=1 → LO=0xFFFFFFFF, HI=0. dividend=0xFFFFFFFF, divisor=0x10000 → LO=0x0000FFFF, HI=0x0000FFFF.
3. dividend=5, divisor=0 → LO=0xFFFFFFFF, HI=5, done asserted normally.
4. First start 100/7, then div_start=1 with 9/3 at cycles 5 and 33 (the DONE cycle) → both ignored; result stays HI=2, LO=14; a start after busy falls gives HI=0, LO=3.
5. After a prior result HI=2, LO=14: start 50/4, hold hilo_sel=00 → stall=1 and rdata=2 throughout busy; after busy falls, stall=0 and rdata=2; sel=01 reads LO=12. sel=10 → rdata=0, stall=0.
6. Start 100/7, assert rst at cycle 10 → next cycle busy=0, done never pulses, HI=LO=0; a fresh 100/7 then completes correctly.
